keypad_code_entry: RTL and testbench
====================================

// Module: keypad_code_entry
// PURPOSE
//  Door/garage keypad front end. Collects decimal key presses from one keypad scanner and
//  converts them to binary codes. Presents in_password / change_password / rs_button to the
//  password checker through a valid/ready handshake.
//  One instance per keypad: room doors sit behind the doorEnable mux, the garage has its own.
// PARAMETERS
//  CODE_W          17     width of binary code outputs
//  MAX_DIGITS      5      max digits per entry; (10^MAX_DIGITS - 1) < 2^CODE_W, else result is mod 2^CODE_W
//  TIMEOUT_CYCLES  50000  inter-key idle limit (used only with KEYPAD_TIMEOUT_EN)
// PORTS
//  clk              in   1       system clock, rising edge
//  reset_n          in   1       asynchronous, active-low reset
//  key_valid        in   1       one-cycle strobe: key_code is valid
//  key_code         in   4       0-9 digit; 4'hA clear; 4'hB backspace; 4'hC change-mode; 4'hE enter; others ignored
//  code_ready       in   1       checker accepts the presented code
//  code_valid       out  1       in_password / change_password / rs_button are valid
//  in_password      out  CODE_W  current or entered code, binary
//  change_password  out  CODE_W  new code (change mode only, else 0)
//  rs_button        out  1       0 = unlock request, 1 = change-password request
//  digit_count      out  3       digits in the current entry
//  entry_error      out  1       1-cycle pulse: digit rejected because buffer is full
//  key_dropped      out  1       1-cycle pulse: key arrived during CONVERT/VALID
//  timeout          out  1       1-cycle pulse: entry abandoned on idle limit
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; digit buffer, mode, and phase cleared.
//  Digits are stored as BCD in a MAX_DIGITS x 4 shift buffer, newest digit in the LSB slot.
//  State IDLE (digit_count = 0):
//   - digit: store it, go to ENTRY.
//   - 4'hC: toggle mode, only when phase = 0.
//   - 4'hA: clear mode and phase.
//   - enter / backspace: ignored.
//  State ENTRY:
//   - digit with digit_count < MAX_DIGITS: shift in, count += 1.
//   - digit with digit_count = MAX_DIGITS: dropped, entry_error pulses.
//   - 4'hB: count -= 1, drop the newest digit; return to IDLE when count reaches 0 (phase kept).
//   - 4'hA: full clear (buffer, mode, phase), go to IDLE.
//   - 4'hE: go to CONVERT.
//   - 4'hC: ignored.
//  State CONVERT:
//   - one digit per cycle, oldest first: acc <= acc*10 + digit, computed at CODE_W bits (mod 2^CODE_W).
//   - latency = digit_count cycles.
//   - result goes to in_password when phase = 0, to change_password when phase = 1.
//   - afterwards: if mode = 1 and phase = 0, set phase = 1, clear buffer, go to IDLE to await the new code.
//     Otherwise go to VALID.
//  State VALID:
//   - code_valid = 1; rs_button = mode; all code outputs held stable.
//   - code_ready = 1: transfer completes that cycle. Next cycle code_valid = 0, outputs zeroed,
//     mode and phase cleared, IDLE.
//  Simultaneous and boundary cases:
//   - key_valid in CONVERT or VALID: key discarded, key_dropped pulses, state unaffected.
//   - code_ready outside VALID: ignored.
//   - code_valid never deasserts without code_ready, except on reset.
//   - entry of 00000 is legal and yields code 0.
//   - reset_n low in any state: immediate return to reset values; a partial entry or a pending
//     code is lost and no code_valid is emitted.
// CONFIGURATION
//  KEYPAD_TIMEOUT_EN defined:
//   - idle counter runs in ENTRY, and in IDLE while mode = 1 or phase = 1.
//   - counter restarts on every accepted key.
//   - reaching TIMEOUT_CYCLES: full clear to IDLE, timeout pulses for 1 cycle.
//   - counter is frozen in CONVERT and VALID.
//  KEYPAD_TIMEOUT_EN undefined: no counter is built, timeout is tied to 0, and a partial entry
//  persists indefinitely.
// TESTING
//  1. Keys 4,5,6,7,5,E; code_ready held 1 -> 5 CONVERT cycles; code_valid for 1 cycle;
//     in_password = 45675, rs_button = 0, change_password = 0.
//  2. Keys C,4,5,6,7,5,E,1,2,3,E; code_ready = 0 for 10 cycles -> code_valid stays 1 with
//     in_password = 45675, change_password = 123, rs_button = 1; code_ready = 1 -> clears next cycle.
//  3. Keys 9,9,9,9,9,9 -> entry_error on the 6th key, digit_count = 5; then E -> in_password = 99999.
//  4. Keys 1,2,B,B,E -> back in IDLE after the second B; E ignored; code_valid never asserts.
//  5. Key 7 during VALID -> key_dropped pulses, in_password unchanged.
//     reset_n low mid-CONVERT -> all outputs 0 immediately.
//  6. KEYPAD_TIMEOUT_EN, TIMEOUT_CYCLES = 20: key 3, then idle for 20 cycles -> timeout pulse,
//     digit_count = 0. Without the macro: no timeout, digit_count stays 1.

Source files
------------

// File: rtl/keypad_code_entry.sv
// keypad_code_entry
//   Keypad front end for one door/garage keypad. Collects decimal key presses
//   into a BCD buffer, converts the entry to binary and presents it to the
//   password checker through a valid/ready handshake. In change mode a second
//   entry (the new code) is collected and presented together with the first.
//
//   Optional build macro: KEYPAD_TIMEOUT_EN
//     defined   - an inter-key idle counter abandons a partial entry after
//                 TIMEOUT_CYCLES idle cycles and pulses timeout.
//     undefined - no counter is built, timeout is tied to 0.
//
// Ports
//   clk              in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   key_valid        in   one-cycle strobe qualifying key_code
//   key_code[3:0]    in   0-9 digit, A clear, B backspace, C change mode, E enter
//   code_ready       in   checker accepts the presented code
//   code_valid       out  presented code is valid
//   in_password      out  current / entered code (binary)
//   change_password  out  new code in change mode, else 0
//   rs_button        out  0 = unlock request, 1 = change-password request
//   digit_count[2:0] out  digits in the current entry
//   entry_error      out  pulse: digit rejected, buffer full
//   key_dropped      out  pulse: key arrived while converting or presenting
//   timeout          out  pulse: entry abandoned on idle limit
module keypad_code_entry #(
    parameter int CODE_W         = 17,
    parameter int MAX_DIGITS     = 5,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              code_ready,
    output logic              code_valid,
    output logic [CODE_W-1:0] in_password,
    output logic [CODE_W-1:0] change_password,
    output logic              rs_button,
    output logic [2:0]        digit_count,
    output logic              entry_error,
    output logic              key_dropped,
    output logic              timeout
);

    localparam logic [3:0]        KEY_CLEAR = 4'hA;
    localparam logic [3:0]        KEY_BACK  = 4'hB;
    localparam logic [3:0]        KEY_MODE  = 4'hC;
    localparam logic [3:0]        KEY_ENTER = 4'hE;
    localparam logic [2:0]        MAX_CNT   = 3'(MAX_DIGITS);
    localparam logic [CODE_W-1:0] TEN       = CODE_W'(10);

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CONVERT, S_VALID} state_t;

    state_t            state, state_next;
    logic [3:0]        digits      [MAX_DIGITS];
    logic [3:0]        digits_next [MAX_DIGITS];
    logic [2:0]        count, count_next;
    logic [2:0]        conv_idx, conv_idx_next;
    logic              mode, mode_next;
    logic              phase, phase_next;
    logic [CODE_W-1:0] in_pw, in_pw_next;
    logic [CODE_W-1:0] chg_pw, chg_pw_next;
    logic              err_next, drop_next;
    logic              clear_all;
    logic              is_digit;
    logic [3:0]        cur_digit;
    logic [CODE_W-1:0] acc_in, acc_out;

    assign is_digit  = (key_code <= 4'd9);
    // Oldest digit sits at index count-1, so conversion walks conv_idx down to 0.
    assign cur_digit = digits[conv_idx];
    assign acc_in    = phase ? chg_pw : in_pw;
    assign acc_out   = acc_in * TEN + CODE_W'(cur_digit);

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt, idle_cnt_next;
    logic          tmo_next;
    logic          idle_run;

    // Counter runs while a partial entry or a pending mode/phase is waiting.
    assign idle_run = (state == S_ENTRY) || ((state == S_IDLE) && (mode || phase));
`endif

    always_comb begin
        state_next    = state;
        for (int i = 0; i < MAX_DIGITS; i++) digits_next[i] = digits[i];
        count_next    = count;
        conv_idx_next = conv_idx;
        mode_next     = mode;
        phase_next    = phase;
        in_pw_next    = in_pw;
        chg_pw_next   = chg_pw;
        err_next      = 1'b0;
        drop_next     = 1'b0;
        clear_all     = 1'b0;

        case (state)
            S_IDLE: begin
                if (key_valid) begin
                    if (is_digit) begin
                        digits_next[0] = key_code;
                        count_next     = 3'd1;
                        state_next     = S_ENTRY;
                    end else if (key_code == KEY_MODE) begin
                        if (!phase) mode_next = ~mode;
                    end else if (key_code == KEY_CLEAR) begin
                        clear_all = 1'b1;
                    end
                end
            end
            S_ENTRY: begin
                if (key_valid) begin
                    if (is_digit) begin
                        if (count < MAX_CNT) begin
                            for (int i = MAX_DIGITS - 1; i > 0; i--) digits_next[i] = digits[i-1];
                            digits_next[0] = key_code;
                            count_next     = count + 3'd1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else if (key_code == KEY_BACK) begin
                        for (int i = 0; i < MAX_DIGITS - 1; i++) digits_next[i] = digits[i+1];
                        digits_next[MAX_DIGITS-1] = 4'd0;
                        count_next = count - 3'd1;
                        if (count == 3'd1) state_next = S_IDLE;
                    end else if (key_code == KEY_CLEAR) begin
                        clear_all = 1'b1;
                    end else if (key_code == KEY_ENTER) begin
                        conv_idx_next = count - 3'd1;
                        state_next    = S_CONVERT;
                    end
                end
            end
            S_CONVERT: begin
                drop_next = key_valid;
                // Target register starts at 0 and accumulates in place.
                if (phase) chg_pw_next = acc_out;
                else       in_pw_next  = acc_out;
                if (conv_idx == 3'd0) begin
                    if (mode && !phase) begin
                        phase_next = 1'b1;
                        for (int i = 0; i < MAX_DIGITS; i++) digits_next[i] = 4'd0;
                        count_next = 3'd0;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_VALID;
                    end
                end else begin
                    conv_idx_next = conv_idx - 3'd1;
                end
            end
            S_VALID: begin
                drop_next = key_valid;
                if (code_ready) clear_all = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase

`ifdef KEYPAD_TIMEOUT_EN
        idle_cnt_next = idle_cnt;
        tmo_next      = 1'b0;
        if (key_valid && (state == S_IDLE || state == S_ENTRY)) begin
            idle_cnt_next = '0;
        end else if (idle_run) begin
            if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                idle_cnt_next = '0;
                tmo_next      = 1'b1;
                clear_all     = 1'b1;
            end else begin
                idle_cnt_next = idle_cnt + 1'b1;
            end
        end else if (state == S_IDLE) begin
            idle_cnt_next = '0;
        end
`endif

        if (clear_all) begin
            state_next  = S_IDLE;
            for (int i = 0; i < MAX_DIGITS; i++) digits_next[i] = 4'd0;
            count_next  = 3'd0;
            mode_next   = 1'b0;
            phase_next  = 1'b0;
            in_pw_next  = '0;
            chg_pw_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            for (int i = 0; i < MAX_DIGITS; i++) digits[i] <= 4'd0;
            count       <= 3'd0;
            conv_idx    <= 3'd0;
            mode        <= 1'b0;
            phase       <= 1'b0;
            in_pw       <= '0;
            chg_pw      <= '0;
            entry_error <= 1'b0;
            key_dropped <= 1'b0;
        end else begin
            state       <= state_next;
            for (int i = 0; i < MAX_DIGITS; i++) digits[i] <= digits_next[i];
            count       <= count_next;
            conv_idx    <= conv_idx_next;
            mode        <= mode_next;
            phase       <= phase_next;
            in_pw       <= in_pw_next;
            chg_pw      <= chg_pw_next;
            entry_error <= err_next;
            key_dropped <= drop_next;
        end
    end

`ifdef KEYPAD_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            idle_cnt <= idle_cnt_next;
            timeout  <= tmo_next;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign code_valid      = (state == S_VALID);
    assign rs_button       = code_valid & mode;
    assign in_password     = in_pw;
    assign change_password = chg_pw;
    assign digit_count     = count;

endmodule

// File: tb/tb_keypad_code_entry.sv
module tb_keypad_code_entry;

    localparam int CODE_W = 17;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              key_valid;
    logic [3:0]        key_code;
    logic              code_ready;
    logic              code_valid;
    logic [CODE_W-1:0] in_password;
    logic [CODE_W-1:0] change_password;
    logic              rs_button;
    logic [2:0]        digit_count;
    logic              entry_error;
    logic              key_dropped;
    logic              timeout;

    typedef struct packed {
        logic [CODE_W-1:0] inp;
        logic [CODE_W-1:0] chg;
        logic              rs;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    keypad_code_entry #(
        .CODE_W(CODE_W),
        .MAX_DIGITS(5),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_valid(key_valid),
        .key_code(key_code),
        .code_ready(code_ready),
        .code_valid(code_valid),
        .in_password(in_password),
        .change_password(change_password),
        .rs_button(rs_button),
        .digit_count(digit_count),
        .entry_error(entry_error),
        .key_dropped(key_dropped),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted transfer is compared against the scoreboard;
    // a valid with nothing expected is an error.
    always @(negedge clk) begin
        if (reset_n && code_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(code_valid), 32'd0);
            end else if (code_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_in_password", 32'(in_password), 32'(e.inp));
                check("mon_change_password", 32'(change_password), 32'(e.chg));
                check("mon_rs_button", 32'(rs_button), 32'(e.rs));
            end
        end
    end

    task automatic press(input logic [3:0] k);
        @(posedge clk); #1;
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk); #1;
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic press_seq(input logic [3:0] ks[$]);
        foreach (ks[i]) press(ks[i]);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!code_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("valid_seen", 32'(code_valid), 32'd1);
    endtask

    task automatic push_exp(input int inp, input int chg, input logic rs);
        exp_t e;
        e.inp = CODE_W'(inp);
        e.chg = CODE_W'(chg);
        e.rs  = rs;
        exp_q.push_back(e);
    endtask

    initial begin
        int cyc;
        bit seen;
        reset_n    = 1'b0;
        key_valid  = 1'b0;
        key_code   = 4'd0;
        code_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_code_valid", 32'(code_valid), 32'd0);
        check("rst_in_password", 32'(in_password), 32'd0);
        check("rst_digit_count", 32'(digit_count), 32'd0);
        check("rst_rs_button", 32'(rs_button), 32'd0);
        reset_n = 1'b1;

        // 1: plain unlock entry, ready held high
        code_ready = 1'b1;
        press_seq('{4'd4, 4'd5, 4'd6, 4'd7, 4'd5});
        check("t1_digit_count", 32'(digit_count), 32'd5);
        push_exp(45675, 0, 1'b0);
        press(4'hE);
        wait_valid(cyc);
        check("t1_latency", 32'(cyc), 32'd5);
        @(posedge clk); #1;
        check("t1_valid_drop", 32'(code_valid), 32'd0);

        // 2: change password, checker stalls for 10 cycles
        code_ready = 1'b0;
        press_seq('{4'hC, 4'd4, 4'd5, 4'd6, 4'd7, 4'd5, 4'hE});
        repeat (6) @(posedge clk);
        #1;
        check("t2_phase0_code", 32'(in_password), 32'd45675);
        check("t2_phase0_valid", 32'(code_valid), 32'd0);
        push_exp(45675, 123, 1'b1);
        press_seq('{4'd1, 4'd2, 4'd3, 4'hE});
        wait_valid(cyc);
        check("t2_latency", 32'(cyc), 32'd3);
        seen = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!code_valid || in_password != 17'd45675 || change_password != 17'd123 || !rs_button)
                seen = 1'b0;
        end
        check("t2_held_stable", 32'(seen), 32'd1);
        code_ready = 1'b1;
        @(posedge clk); #1;
        check("t2_valid_drop", 32'(code_valid), 32'd0);
        check("t2_outputs_zero", 32'(in_password | change_password), 32'd0);
        check("t2_rs_zero", 32'(rs_button), 32'd0);

        // 3: buffer full
        press_seq('{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9});
        check("t3_entry_error", 32'(entry_error), 32'd1);
        check("t3_digit_count", 32'(digit_count), 32'd5);
        @(posedge clk); #1;
        check("t3_error_pulse", 32'(entry_error), 32'd0);
        push_exp(99999, 0, 1'b0);
        press(4'hE);
        wait_valid(cyc);
        @(posedge clk); #1;

        // 3b: all-zero entry is legal
        push_exp(0, 0, 1'b0);
        press_seq('{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'hE});
        wait_valid(cyc);
        check("t3b_latency", 32'(cyc), 32'd5);
        @(posedge clk); #1;

        // 4: backspace back to IDLE, enter ignored
        press_seq('{4'd1, 4'd2, 4'hB});
        check("t4_count_after_b", 32'(digit_count), 32'd1);
        press_seq('{4'hB, 4'hE});
        check("t4_count_zero", 32'(digit_count), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (code_valid) seen = 1'b1;
        end
        check("t4_no_valid", 32'(seen), 32'd0);

        // 5: key during VALID is dropped
        code_ready = 1'b0;
        push_exp(31, 0, 1'b0);
        press_seq('{4'd3, 4'd1, 4'hE});
        wait_valid(cyc);
        press(4'd7);
        check("t5_key_dropped", 32'(key_dropped), 32'd1);
        check("t5_in_password", 32'(in_password), 32'd31);
        check("t5_still_valid", 32'(code_valid), 32'd1);
        code_ready = 1'b1;
        @(posedge clk); #1;
        check("t5_valid_drop", 32'(code_valid), 32'd0);

        // 5b: reset in the middle of a conversion
        press_seq('{4'd8, 4'd8, 4'd8, 4'hE});
        @(posedge clk); #1;
        check("t5b_partial", 32'(in_password), 32'd8);
        reset_n = 1'b0;
        #1;
        check("t5b_rst_in_password", 32'(in_password), 32'd0);
        check("t5b_rst_count", 32'(digit_count), 32'd0);
        check("t5b_rst_valid", 32'(code_valid), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t5b_no_valid_after", 32'(code_valid), 32'd0);

        // 6: idle timeout
        press(4'd3);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (timeout) seen = 1'b1;
        end
`ifdef KEYPAD_TIMEOUT_EN
        check("t6_timeout_seen", 32'(seen), 32'd1);
        check("t6_count_cleared", 32'(digit_count), 32'd0);
`else
        check("t6_no_timeout", 32'(seen), 32'd0);
        check("t6_count_kept", 32'(digit_count), 32'd1);
`endif
        press(4'hA);
        check("t6_cleared", 32'(digit_count), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
